// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and state encoding for the moving-box motion scheduler
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_CALC   = 2'd2,
        ST_COMMIT = 2'd3
    } vga_state_t;

endpackage

// File: rtl/vga_axis_step.sv
// rtl/vga_axis_step.sv - one-axis next position/direction with edge bounce
module vga_axis_step #(
    parameter int MAX  = 576,
    parameter int STEP = 2
) (
    input  logic [9:0] pos,
    input  logic       dir,
    output logic [9:0] pos_next,
    output logic       dir_next,
    output logic       hit
);

    localparam logic [10:0] MAX_W   = 11'(MAX);
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [9:0]  MAX_10  = 10'(MAX);
    localparam logic [9:0]  STEP_10 = 10'(STEP);

    logic [10:0] sum;

    always_comb begin
        sum      = {1'b0, pos} + STEP_W;
        pos_next = pos;
        dir_next = dir;
        hit      = 1'b0;
        if (dir) begin
            if (sum >= MAX_W) begin
                pos_next = MAX_10;
                dir_next = 1'b0;
                hit      = 1'b1;
            end else begin
                pos_next = sum[9:0];
            end
        end else begin
            // Landing exactly on zero counts as a reflection.
            if ({1'b0, pos} <= STEP_W) begin
                pos_next = '0;
                dir_next = 1'b1;
                hit      = 1'b1;
            end else begin
                pos_next = pos - STEP_10;
            end
        end
    end

endmodule

// File: rtl/vga_move_ctrl.sv
// rtl/vga_move_ctrl.sv - per-frame box motion scheduler; VGA_MOVE_HITCNT_EN adds hit_cnt
module vga_move_ctrl #(
    parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
    parameter int BOX_W     = 64,
    parameter int BOX_H     = 48,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1
) (
    input  logic       sclk,
    input  logic       srst,
    input  logic       frame_start,
    input  logic       run_en,
    input  logic       step_req,
    output logic       step_ack,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       bounce,
    output logic       busy
`ifdef VGA_MOVE_HITCNT_EN
    ,
    output logic [15:0] hit_cnt
`endif
);

    import vga_pkg::*;

    localparam int         MAX_X    = H_ACTIVE - BOX_W;
    localparam int         MAX_Y    = V_ACTIVE - BOX_H;
    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    vga_state_t state_q, state_d;
    logic [7:0] div_cnt;
    logic       step_mode;
    logic       load, set_step, div_inc, div_clr;
    logic [9:0] nx_x, nx_y;
    logic       nd_x, nd_y, hit_x, hit_y;

    vga_axis_step #(.MAX(MAX_X), .STEP(STEP)) u_axis_x (
        .pos      (box_x),
        .dir      (dir_x),
        .pos_next (nx_x),
        .dir_next (nd_x),
        .hit      (hit_x)
    );

    vga_axis_step #(.MAX(MAX_Y), .STEP(STEP)) u_axis_y (
        .pos      (box_y),
        .dir      (dir_y),
        .pos_next (nx_y),
        .dir_next (nd_y),
        .hit      (hit_y)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        set_step = 1'b0;
        div_inc  = 1'b0;
        div_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_en) begin
                    state_d = ST_WAIT;
                end else if (step_req) begin
                    state_d  = ST_WAIT;
                    set_step = 1'b1;
                end
            end
            ST_WAIT: begin
                if (run_en) begin
                    if (frame_start) begin
                        if (div_cnt == DIV_LAST) begin
                            div_clr = 1'b1;
                            state_d = ST_CALC;
                        end else begin
                            div_inc = 1'b1;
                        end
                    end
                end else if (step_mode) begin
                    if (frame_start) state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // Results are registered at the end of CALC so they are visible throughout COMMIT.
            ST_CALC: begin
                load    = 1'b1;
                state_d = ST_COMMIT;
            end
            default: begin
                state_d = run_en ? ST_WAIT : ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q   <= ST_IDLE;
            div_cnt   <= '0;
            step_mode <= 1'b0;
            box_x     <= '0;
            box_y     <= '0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            bounce    <= 1'b0;
            step_ack  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (div_clr) begin
                div_cnt <= '0;
            end else if (div_inc) begin
                div_cnt <= div_cnt + 8'd1;
            end
            if (run_en) begin
                step_mode <= 1'b0;
            end else if (set_step) begin
                step_mode <= 1'b1;
            end else if (state_q == ST_COMMIT) begin
                step_mode <= 1'b0;
            end
            bounce   <= 1'b0;
            step_ack <= 1'b0;
            if (load) begin
                box_x    <= nx_x;
                box_y    <= nx_y;
                dir_x    <= nd_x;
                dir_y    <= nd_y;
                bounce   <= hit_x | hit_y;
                step_ack <= step_mode & ~run_en;
            end
        end
    end

    assign busy = (state_q == ST_CALC) || (state_q == ST_COMMIT);

`ifdef VGA_MOVE_HITCNT_EN
    always_ff @(posedge sclk) begin
        if (srst) begin
            hit_cnt <= '0;
        end else if (load && (hit_x || hit_y) && (hit_cnt != 16'hFFFF)) begin
            hit_cnt <= hit_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_move_ctrl.sv
// tb/tb_vga_move_ctrl.sv - self-checking bench for vga_move_ctrl (three parameterisations)
module tb_vga_move_ctrl;

    localparam int MAXX = 576;
    localparam int MAXY = 432;

    logic sclk = 1'b0;
    logic srst, frame_start, run_en, step_req;

    logic [9:0]  bx[3];
    logic [9:0]  by[3];
    logic        dxo[3], dyo[3], bnc[3], bsy[3], sack[3];
`ifdef VGA_MOVE_HITCNT_EN
    logic [15:0] hc[3];
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_ack    = 0;
    bit chk_en   = 1'b0;

    int P_STEP[3] = '{2, 5, 2};
    int P_DIV[3]  = '{1, 1, 3};

    int m_x[3], m_y[3], m_div[3], m_cd[3], m_hits[3];
    bit m_dx[3], m_dy[3], m_wait[3], m_step[3], m_bnc[3], m_ack[3];

    always #5 sclk = ~sclk;

    vga_move_ctrl u_dut (
        .sclk(sclk), .srst(srst), .frame_start(frame_start), .run_en(run_en),
        .step_req(step_req), .step_ack(sack[0]), .box_x(bx[0]), .box_y(by[0]),
        .dir_x(dxo[0]), .dir_y(dyo[0]), .bounce(bnc[0]), .busy(bsy[0])
`ifdef VGA_MOVE_HITCNT_EN
        , .hit_cnt(hc[0])
`endif
    );

    vga_move_ctrl #(.STEP(5)) u_dut_s5 (
        .sclk(sclk), .srst(srst), .frame_start(frame_start), .run_en(run_en),
        .step_req(step_req), .step_ack(sack[1]), .box_x(bx[1]), .box_y(by[1]),
        .dir_x(dxo[1]), .dir_y(dyo[1]), .bounce(bnc[1]), .busy(bsy[1])
`ifdef VGA_MOVE_HITCNT_EN
        , .hit_cnt(hc[1])
`endif
    );

    vga_move_ctrl #(.FRAME_DIV(3)) u_dut_d3 (
        .sclk(sclk), .srst(srst), .frame_start(frame_start), .run_en(run_en),
        .step_req(step_req), .step_ack(sack[2]), .box_x(bx[2]), .box_y(by[2]),
        .dir_x(dxo[2]), .dir_y(dyo[2]), .bounce(bnc[2]), .busy(bsy[2])
`ifdef VGA_MOVE_HITCNT_EN
        , .hit_cnt(hc[2])
`endif
    );

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reflection rule: overshoot or exact landing clamps to the edge and flips direction.
    task automatic move(inout int p, inout bit d, input int s, input int mx, output bit hit);
        int t;
        t   = d ? p + s : p - s;
        hit = d ? (t >= mx) : (t <= 0);
        if (hit) begin
            p = d ? mx : 0;
            d = !d;
        end else begin
            p = t;
        end
    endtask

    // Transaction model: an accepted frame schedules an update two edges later.
    always @(posedge sclk) begin
        for (int i = 0; i < 3; i++) begin
            bit hx, hy;
            if (srst) begin
                m_x[i] = 0; m_y[i] = 0; m_dx[i] = 1; m_dy[i] = 1;
                m_div[i] = 0; m_cd[i] = 0; m_wait[i] = 0; m_step[i] = 0;
                m_bnc[i] = 0; m_ack[i] = 0; m_hits[i] = 0;
            end else begin
                m_bnc[i] = 0;
                m_ack[i] = 0;
                if (m_cd[i] == 2) begin
                    move(m_x[i], m_dx[i], P_STEP[i], MAXX, hx);
                    move(m_y[i], m_dy[i], P_STEP[i], MAXY, hy);
                    m_bnc[i] = hx | hy;
                    m_ack[i] = m_step[i] && !run_en;
                    if (m_bnc[i] && m_hits[i] < 65535) m_hits[i]++;
                    m_cd[i] = 1;
                end else if (m_cd[i] == 1) begin
                    m_cd[i]   = 0;
                    m_wait[i] = run_en;
                    m_step[i] = 0;
                end else if (!m_wait[i]) begin
                    if (run_en) m_wait[i] = 1;
                    else if (step_req) begin m_wait[i] = 1; m_step[i] = 1; end
                end else if (run_en) begin
                    if (frame_start) begin
                        if (m_div[i] == P_DIV[i] - 1) begin m_div[i] = 0; m_cd[i] = 2; end
                        else m_div[i]++;
                    end
                end else if (m_step[i]) begin
                    if (frame_start) m_cd[i] = 2;
                end else begin
                    m_wait[i] = 0;
                end
                if (run_en) m_step[i] = 0;
            end
        end
    end

    always @(negedge sclk) begin
        if (chk_en) begin
            if (sack[0]) n_ack++;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("box_x[%0d]", i), int'(bx[i]), m_x[i]);
                check($sformatf("box_y[%0d]", i), int'(by[i]), m_y[i]);
                check($sformatf("dir_x[%0d]", i), int'(dxo[i]), int'(m_dx[i]));
                check($sformatf("dir_y[%0d]", i), int'(dyo[i]), int'(m_dy[i]));
                check($sformatf("bounce[%0d]", i), int'(bnc[i]), int'(m_bnc[i]));
                check($sformatf("step_ack[%0d]", i), int'(sack[i]), int'(m_ack[i]));
                check($sformatf("busy[%0d]", i), int'(bsy[i]), (m_cd[i] != 0) ? 1 : 0);
`ifdef VGA_MOVE_HITCNT_EN
                check($sformatf("hit_cnt[%0d]", i), int'(hc[i]), m_hits[i]);
`endif
            end
        end
    end

    // Leaves the caller at the negedge of the cycle where the update becomes visible.
    task automatic pulse_frame(input bit drop_on_ack);
        @(posedge sclk); #1 frame_start = 1'b1;
        @(posedge sclk); #1 frame_start = 1'b0;
        @(negedge sclk);
        @(negedge sclk);
        if (drop_on_ack && sack[0]) step_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge sclk); #1 srst = 1'b1;
        @(posedge sclk); #1 srst = 1'b0;
    endtask

    initial begin
        srst = 1'b1; frame_start = 1'b0; run_en = 1'b0; step_req = 1'b0;
        @(posedge sclk); @(posedge sclk);
        @(negedge sclk);
        chk_en = 1'b1;
        check("reset box_x", int'(bx[0]), 0);
        check("reset dir_x", int'(dxo[0]), 1);
        check("reset dir_y", int'(dyo[0]), 1);
        check("reset busy", int'(bsy[0]), 0);
        @(posedge sclk); #1 srst = 1'b0; run_en = 1'b1;

        for (int f = 1; f <= 289; f++) begin
            pulse_frame(1'b0);
            if (f == 1) begin
                check("first box_x", int'(bx[0]), 2);
                check("first box_y", int'(by[0]), 2);
                check("first bounce", int'(bnc[0]), 0);
                check("first busy", int'(bsy[0]), 1);
            end
            if (f == 6) check("div3 box_x", int'(bx[2]), 4);
            if (f == 116) begin
                check("step5 clamp box_x", int'(bx[1]), 576);
                check("step5 dir_x", int'(dxo[1]), 0);
            end
            if (f == 216) begin
                check("bottom box_y", int'(by[0]), 432);
                check("bottom dir_y", int'(dyo[0]), 0);
                check("bottom bounce", int'(bnc[0]), 1);
            end
            if (f == 288) begin
                check("right box_x", int'(bx[0]), 576);
                check("right dir_x", int'(dxo[0]), 0);
                check("right bounce", int'(bnc[0]), 1);
            end
            if (f == 289) check("after right box_x", int'(bx[0]), 574);
            repeat (3) @(negedge sclk);
        end

        run_en = 1'b0;
        do_reset();
        @(posedge sclk); #1 step_req = 1'b1;
        repeat (2) @(posedge sclk);
        for (int f = 0; f < 3; f++) begin
            pulse_frame(1'b1);
            repeat (3) @(negedge sclk);
        end
        check("step box_x", int'(bx[0]), 2);
        check("step div3 box_x", int'(bx[2]), 2);
        check("step ack count", n_ack, 1);

        @(posedge sclk); #1 run_en = 1'b1; step_req = 1'b1;
        for (int f = 0; f < 2; f++) begin
            pulse_frame(1'b0);
            repeat (3) @(negedge sclk);
        end
        check("run ignores step ack count", n_ack, 1);
        check("run after step box_x", int'(bx[0]), 6);
        step_req = 1'b0;

        @(posedge sclk); #1 frame_start = 1'b1;
        @(posedge sclk); #1 frame_start = 1'b0; srst = 1'b1;
        @(posedge sclk); #1 srst = 1'b0;
        @(negedge sclk);
        check("calc reset box_x", int'(bx[0]), 0);
        check("calc reset dir_y", int'(dyo[0]), 1);
        check("calc reset busy", int'(bsy[0]), 0);
`ifdef VGA_MOVE_HITCNT_EN
        check("calc reset hit_cnt", int'(hc[0]), 0);
`endif
        repeat (4) @(negedge sclk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
